// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating mux with a registered valid/ready output stage.
// Ports: clk, reset (async, active high); in_valid/in_data/in_ready per channel;
//        out_valid/out_data/out_sel/out_ready towards the single consumer.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [(N > 2 ? $clog2(N) : 1)-1:0] out_sel,
    input  logic               out_ready
);

    localparam int SW = (N > 2) ? $clog2(N) : 1;

    logic [WIDTH-1:0] chan [N];
    logic [N-1:0]     grant;
    logic [SW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             load_en;
    logic             take;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic [SW-1:0]    out_sel_d, out_sel_q;
    logic [SW-1:0]    ptr_d, ptr_q;

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign chan[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Search order starts at the pointer (round-robin) or at 0 (fixed
    // priority); the sum is folded back below N so odd N wraps correctly.
    always_comb begin
        int      sum;
        logic [SW-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 1) begin
                sum = k;
            end else begin
                sum = int'(ptr_q) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
            end
            idx = SW'(sum);
            if (!gnt_any && in_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                gnt_any    = 1'b1;
            end
        end
    end

    // Register may load when empty or when it is being drained this cycle.
    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = (load_en && !reset) ? grant : '0;
    assign take     = gnt_any && load_en && !reset;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = chan[gnt_idx];
            out_sel_d   = gnt_idx;
            if (MODE == 0) begin
                ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of rr_arb_mux in three configurations:
// N=4 round-robin, N=4 fixed priority, N=3 WIDTH=8 round-robin.
module tb_rr_arb_mux;

    logic clk;
    logic reset;

    // N=4, MODE 0
    logic [3:0]   iv_a;
    logic [127:0] id_a;
    logic [3:0]   ir_a;
    logic         ov_a;
    logic [31:0]  od_a;
    logic [1:0]   os_a;
    logic         or_a;

    // N=4, MODE 1
    logic [3:0]   iv_b;
    logic [127:0] id_b;
    logic [3:0]   ir_b;
    logic         ov_b;
    logic [31:0]  od_b;
    logic [1:0]   os_b;
    logic         or_b;

    // N=3, WIDTH=8, MODE 0
    logic [2:0]   iv_c;
    logic [23:0]  id_c;
    logic [2:0]   ir_c;
    logic         ov_c;
    logic [7:0]   od_c;
    logic [1:0]   os_c;
    logic         or_c;

    int checks = 0;
    int errors = 0;

    rr_arb_mux #(.WIDTH(32), .N(4), .MODE(0)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_sel(os_a),
        .out_ready(or_a)
    );

    rr_arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_sel(os_b),
        .out_ready(or_b)
    );

    rr_arb_mux #(.WIDTH(8), .N(3), .MODE(0)) u_c (
        .clk(clk), .reset(reset),
        .in_valid(iv_c), .in_data(id_c), .in_ready(ir_c),
        .out_valid(ov_c), .out_data(od_c), .out_sel(os_c),
        .out_ready(or_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a_data();
        for (int i = 0; i < 4; i++) begin
            id_a[i*32 +: 32] = 32'hA0 + i;
        end
    endtask

    initial begin
        reset = 1'b1;
        iv_a = 4'hF; or_a = 1'b1; set_a_data();
        iv_b = 4'h0; or_b = 1'b1;
        for (int i = 0; i < 4; i++) id_b[i*32 +: 32] = 32'hC0 + i;
        iv_c = 3'b000; or_c = 1'b1;
        for (int i = 0; i < 3; i++) id_c[i*8 +: 8] = 8'h30 + 8'(i);

        // Reset state
        #3;
        chk("rst_ov", 32'(ov_a), 32'd0);
        chk("rst_od", od_a, 32'd0);
        chk("rst_os", 32'(os_a), 32'd0);
        chk("rst_ir", 32'(ir_a), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_ir0", 32'(ir_a), 32'h1);

        // Round-robin fairness, one word per cycle
        for (int i = 0; i < 8; i++) begin
            chk("rr_ir", 32'(ir_a), 32'(1 << (i % 4)));
            tick();
            chk("rr_ov", 32'(ov_a), 32'd1);
            chk("rr_os", 32'(os_a), 32'(i % 4));
            chk("rr_od", od_a, 32'hA0 + 32'(i % 4));
        end

        // Sparse requests, pointer now 0
        iv_a = 4'b0100;
        #1;
        chk("sp_ir2", 32'(ir_a), 32'b0100);
        tick();
        chk("sp_os2", 32'(os_a), 32'd2);
        chk("sp_od2", od_a, 32'hA2);
        iv_a = 4'b0011;
        #1;
        chk("sp_ir0", 32'(ir_a), 32'b0001);
        tick();
        chk("sp_os0", 32'(os_a), 32'd0);
        chk("sp_ir1", 32'(ir_a), 32'b0010);
        tick();
        chk("sp_os1", 32'(os_a), 32'd1);
        chk("sp_od1", od_a, 32'hA1);
        iv_a = 4'b0000;
        #1;
        chk("sp_irz", 32'(ir_a), 32'd0);
        tick();
        chk("sp_ov0", 32'(ov_a), 32'd0);
        chk("sp_hold", 32'(os_a), 32'd1);

        // Backpressure, pointer now 2
        id_a[32 +: 32] = 32'h55;
        iv_a = 4'b0010;
        tick();
        chk("bp_od", od_a, 32'h55);
        chk("bp_os", 32'(os_a), 32'd1);
        set_a_data();
        iv_a = 4'hF;
        or_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ir", 32'(ir_a), 32'd0);
            tick();
            chk("bp_ov", 32'(ov_a), 32'd1);
            chk("bp_odh", od_a, 32'h55);
            chk("bp_osh", 32'(os_a), 32'd1);
        end
        or_a = 1'b1;
        #1;
        chk("bp_rel_ir", 32'(ir_a), 32'b0100);
        tick();
        chk("bp_rel_os", 32'(os_a), 32'd2);
        chk("bp_rel_od", od_a, 32'hA2);

        // Mid-stream reset while a word is held (pointer 3)
        tick();
        chk("mr_os3", 32'(os_a), 32'd3);
        or_a = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mr_ov", 32'(ov_a), 32'd0);
        chk("mr_od", od_a, 32'd0);
        chk("mr_os", 32'(os_a), 32'd0);
        chk("mr_ir", 32'(ir_a), 32'd0);
        #2;
        reset = 1'b0;
        or_a = 1'b1;
        #1;
        chk("mr_ir0", 32'(ir_a), 32'h1);
        tick();
        chk("mr_first", 32'(os_a), 32'd0);
        iv_a = 4'h0;

        // Fixed priority
        iv_b = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fp_os", 32'(os_b), 32'd0);
            chk("fp_od", od_b, 32'hC0);
        end
        iv_b = 4'b1110;
        #1;
        chk("fp_ir1", 32'(ir_b), 32'b0010);
        tick();
        chk("fp_os1", 32'(os_b), 32'd1);
        chk("fp_od1", od_b, 32'hC1);
        iv_b = 4'b1000;
        tick();
        chk("fp_os3", 32'(os_b), 32'd3);
        iv_b = 4'h0;

        // Non-power-of-two N=3
        iv_c = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("n3_ov", 32'(ov_c), 32'd1);
            chk("n3_os", 32'(os_c), 32'(i % 3));
            chk("n3_od", 32'(od_c), 32'h30 + 32'(i % 3));
        end
        iv_c = 3'b100;
        tick();
        chk("n3_os2", 32'(os_c), 32'd2);
        iv_c = 3'b011;
        #1;
        chk("n3_wrap", 32'(ir_c), 32'b001);
        tick();
        chk("n3_os0", 32'(os_c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
